// File: rtl/udp_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package udp_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    function automatic int unsigned tbl_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Tables are at most 64 entries wide; callers zero-extend into this.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/udp_settle_timer.sv
// 8-bit settle down-counter: loaded on a new vector, expire_c flags the last settle cycle.
module udp_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       expire_c
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expire_c = (cnt == 8'd0);

endmodule

// File: rtl/udp_truth_table_sweeper.sv
// Self-check sequencer: sweeps all input vectors of a custom-logic primitive and compares its truth table.
// Optional lowest-mismatch reporting is built when UDP_SWEEP_FIRST_FAIL_EN is defined.
module udp_truth_table_sweeper
    import udp_sweep_pkg::*;
#(
    parameter int unsigned  N_IN          = 3,
    parameter int unsigned  SETTLE_CYCLES = 2,
    localparam int unsigned TBL_W         = tbl_w(N_IN),
    localparam int unsigned CNT_W         = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [TBL_W-1:0] expected_i,
    input  logic             f_i,
    output logic [N_IN-1:0]  vec_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [TBL_W-1:0] table_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic [N_IN-1:0]  first_fail_o,
    output logic             first_fail_v_o
);

    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(TBL_W - 1);
    // Timer holds SETTLE_CYCLES-1 so that SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam logic [7:0]      SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam sweep_state_t    STEP_STATE  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    sweep_state_t     state;
    logic [N_IN-1:0]  idx;
    logic [TBL_W-1:0] exp_q;
    logic [TBL_W-1:0] tbl_next_c;
    logic [TBL_W-1:0] diff_next_c;
    logic             accept_c;
    logic             last_c;
    logic             step_c;
    logic             finish_c;
    logic             settle_done_c;

    // Table as it will look after the current sample is folded in.
    always_comb begin
        tbl_next_c      = table_o;
        tbl_next_c[idx] = f_i;
        diff_next_c     = tbl_next_c ^ exp_q;
    end

    assign accept_c = (state == IDLE) && start_i && !abort_i;
    assign last_c   = (idx == LAST_IDX);
    assign step_c   = (state == SAMPLE) && !abort_i && !last_c;
    assign finish_c = (state == SAMPLE) && !abort_i && last_c;

    udp_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_c || step_c),
        .load_val (SETTLE_LOAD),
        .en       (state == SETTLE),
        .expire_c (settle_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            exp_q          <= '0;
            vec_o          <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            table_o        <= '0;
            pass_o         <= 1'b0;
            mismatch_cnt_o <= '0;
        end else if (abort_i && (state != IDLE)) begin
            // Partial table is left in place for inspection.
            state  <= IDLE;
            idx    <= '0;
            vec_o  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            pass_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        exp_q          <= expected_i;
                        table_o        <= '0;
                        pass_o         <= 1'b0;
                        mismatch_cnt_o <= '0;
                        idx            <= '0;
                        vec_o          <= '0;
                        busy_o         <= 1'b1;
                        state          <= STEP_STATE;
                    end
                end
                SETTLE: begin
                    if (settle_done_c) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_o <= tbl_next_c;
                    if (last_c) begin
                        state          <= DONE;
                        done_o         <= 1'b1;
                        pass_o         <= (diff_next_c == '0);
                        mismatch_cnt_o <= CNT_W'(popcount(64'(diff_next_c)));
                    end else begin
                        idx   <= idx + N_IN'(1);
                        vec_o <= idx + N_IN'(1);
                        state <= STEP_STATE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    idx    <= '0;
                    vec_o  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDP_SWEEP_FIRST_FAIL_EN
    logic [N_IN-1:0] ff_idx_c;

    // Priority encoder: lowest mismatching index wins.
    always_comb begin
        ff_idx_c = '0;
        for (int k = int'(TBL_W) - 1; k >= 0; k--) begin
            if (diff_next_c[k]) begin
                ff_idx_c = N_IN'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_o   <= '0;
            first_fail_v_o <= 1'b0;
        end else if (accept_c) begin
            first_fail_o   <= '0;
            first_fail_v_o <= 1'b0;
        end else if (finish_c) begin
            first_fail_o   <= ff_idx_c;
            first_fail_v_o <= |diff_next_c;
        end
    end
`else
    assign first_fail_o   = '0;
    assign first_fail_v_o = 1'b0;
`endif

endmodule

// File: tb/tb_udp_truth_table_sweeper.sv
// Directed bench for udp_truth_table_sweeper driving a 3-input majority primitive (table 8'hE8).
module tb_udp_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       abort_i;
    logic [7:0] expected_i;
    logic       f;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] mis;
    logic [2:0] ff;
    logic       ffv;

    logic       z_start;
    logic       z_abort;
    logic       z_f;
    logic [2:0] z_vec;
    logic       z_busy;
    logic       z_done;
    logic [7:0] z_tbl;
    logic       z_pass;
    logic [3:0] z_mis;
    logic [2:0] z_ff;
    logic       z_ffv;

    int total;
    int bad;

    assign f   = (vec[2] & vec[1]) | (vec[1] & vec[0]) | (vec[2] & vec[0]);
    assign z_f = (z_vec[2] & z_vec[1]) | (z_vec[1] & z_vec[0]) | (z_vec[2] & z_vec[0]);

    udp_truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .expected_i(expected_i), .f_i(f), .vec_o(vec), .busy_o(busy), .done_o(done),
        .table_o(tbl), .pass_o(pass), .mismatch_cnt_o(mis),
        .first_fail_o(ff), .first_fail_v_o(ffv)
    );

    udp_truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) dut_fast (
        .clk(clk), .rst_n(rst_n), .start_i(z_start), .abort_i(z_abort),
        .expected_i(8'hE8), .f_i(z_f), .vec_o(z_vec), .busy_o(z_busy), .done_o(z_done),
        .table_o(z_tbl), .pass_o(z_pass), .mismatch_cnt_o(z_mis),
        .first_fail_o(z_ff), .first_fail_v_o(z_ffv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Start a sweep on the main DUT and follow it until done_o (bounded).
    task automatic run_sweep(input logic [7:0] exp_tbl, output int lat, output int vec_err, output int busy_err);
        lat      = -1;
        vec_err  = 0;
        busy_err = 0;
        @(negedge clk);
        expected_i = exp_tbl;
        start_i    = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
            if (vec !== 3'(e / 3)) vec_err++;
            if (busy !== 1'b1) busy_err++;
        end
    endtask

    typedef struct {
        logic [7:0] exp_in;
        logic       pass;
        int         mis;
        int         ff;
    } row_t;

    row_t rows[7];
    int   lat, verr, berr, dones;

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        expected_i = 8'h00;
        z_start    = 1'b0;
        z_abort    = 1'b0;

        rows[0] = '{8'hE8, 1'b1, 0, 0};
        rows[1] = '{8'hE9, 1'b0, 1, 0};
        rows[2] = '{8'h00, 1'b0, 4, 3};
        rows[3] = '{8'hFF, 1'b0, 4, 0};
        rows[4] = '{8'h17, 1'b0, 8, 0};
        rows[5] = '{8'hE0, 1'b0, 1, 3};
        rows[6] = '{8'h68, 1'b0, 1, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_vec", 32'(vec), 0);
        chk("reset_table", 32'(tbl), 0);
        chk("reset_pass", 32'(pass), 0);
        chk("reset_mis", 32'(mis), 0);
        chk("reset_ff", 32'({ffv, ff}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven sweeps.
        for (int r = 0; r < 7; r++) begin
            run_sweep(rows[r].exp_in, lat, verr, berr);
            chk($sformatf("row%0d_latency", r), 32'(lat), 24);
            chk($sformatf("row%0d_vec_steps", r), 32'(verr), 0);
            chk($sformatf("row%0d_busy", r), 32'(berr), 0);
            chk($sformatf("row%0d_table", r), 32'(tbl), 32'h0000_00E8);
            chk($sformatf("row%0d_pass", r), 32'(pass), 32'(rows[r].pass));
            chk($sformatf("row%0d_mis", r), 32'(mis), 32'(rows[r].mis));
`ifdef UDP_SWEEP_FIRST_FAIL_EN
            chk($sformatf("row%0d_ff", r), 32'(ff), 32'(rows[r].ff));
            chk($sformatf("row%0d_ffv", r), 32'(ffv), 32'(!rows[r].pass));
`else
            chk($sformatf("row%0d_ff", r), 32'({ffv, ff}), 0);
`endif
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_idle_busy", r), 32'(busy), 0);
            chk($sformatf("row%0d_idle_done", r), 32'(done), 0);
            chk($sformatf("row%0d_idle_vec", r), 32'(vec), 0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("row%0d_hold_mis", r), 32'(mis), 32'(rows[r].mis));
        end

        // Abort mid-sweep: abort sampled at edge 11 in SETTLE of vector 3.
        @(negedge clk);
        expected_i = 8'hE8;
        start_i    = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_vec", 32'(vec), 0);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_table", 32'(tbl), 0);
        dones = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        chk("abort_no_done", 32'(dones), 0);
        run_sweep(8'hE8, lat, verr, berr);
        chk("after_abort_latency", 32'(lat), 24);
        chk("after_abort_pass", 32'(pass), 1);
        @(posedge clk);

        // start_i held high: accepts at edges 0 and 26 only.
        @(negedge clk);
        expected_i = 8'hE8;
        start_i    = 1'b1;
        dones      = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start_i = 1'b0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("held_start_dones", 32'(dones), 2);
        chk("held_start_idle", 32'(busy), 0);

        // start_i with abort_i in IDLE: nothing starts.
        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        berr    = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            if (busy) berr++;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", 32'(berr), 0);

        // Asynchronous reset during SAMPLE of vector 4 (cycle after edge 14).
        @(negedge clk);
        expected_i = 8'hE8;
        start_i    = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        chk("pre_reset_vec", 32'(vec), 4);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 0);
        chk("async_reset_vec", 32'(vec), 0);
        chk("async_reset_table", 32'(tbl), 0);
        chk("async_reset_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        berr  = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (busy || done) berr++;
        end
        chk("post_reset_idle", 32'(berr), 0);
        run_sweep(8'hE8, lat, verr, berr);
        chk("post_reset_latency", 32'(lat), 24);
        chk("post_reset_pass", 32'(pass), 1);

        // Zero settle time: vec advances every cycle, done after edge 8.
        @(negedge clk);
        z_start = 1'b1;
        @(posedge clk);
        #1 z_start = 1'b0;
        chk("fast_accept_busy", 32'(z_busy), 1);
        lat  = -1;
        verr = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (z_done) begin
                lat = e;
                break;
            end
            if (z_vec !== 3'(e)) verr++;
        end
        chk("fast_latency", 32'(lat), 8);
        chk("fast_vec_steps", 32'(verr), 0);
        chk("fast_table", 32'(z_tbl), 32'h0000_00E8);
        chk("fast_pass", 32'(z_pass), 1);
        chk("fast_mis", 32'(z_mis), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
